// File: rtl/line_rd_sequencer.sv
// Line-buffer read sequencer: replays one buffered row num_rep times into a 2-entry skid queue.
// Optional per-pixel end-of-row flag on out_last when LINE_RD_LAST_EN is defined.
module line_rd_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_LEN    = 10,
  parameter int unsigned ADD_WIDTH  = 4,
  parameter int unsigned REP_WIDTH  = 4
) (
  input  logic                  clk2,
  input  logic                  rd_clr,
  input  logic                  start,
  input  logic [REP_WIDTH-1:0]  num_rep,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_inc,
  output logic                  fifo_rd_clr,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
`ifdef LINE_RD_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int unsigned COL_LAST = ROW_LEN - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_REWIND = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [1:0]            occ, occ_nx;
  logic                  inflight;
  logic [ADD_WIDTH-1:0]  col;
  logic [REP_WIDTH-1:0]  rep_left;
  logic [DATA_WIDTH-1:0] q1_data;
  logic                  push, pop, credit_ok, col_wrap, done_nx;
`ifdef LINE_RD_LAST_EN
  logic                  inflight_last;
  logic                  q1_last;
`endif

  assign out_valid   = (occ != 2'd0);
  assign fifo_rd_inc = fifo_rd_en;

  // State register
  always_ff @(posedge clk2 or posedge rd_clr) begin
    if (rd_clr) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Credit check, read issue and next-state decode
  always_comb begin
    push      = inflight;
    pop       = out_valid & out_ready;
    credit_ok = (3'({1'b0, occ}) + 3'(inflight)) < (3'd2 + 3'(pop));
    col_wrap  = (col == ADD_WIDTH'(COL_LAST));
    fifo_rd_en = 1'b0;
    state_nx   = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (num_rep != '0) ? S_READ : S_DRAIN;
      end
      S_READ: begin
        fifo_rd_en = credit_ok;
        if (credit_ok && col_wrap)
          state_nx = (rep_left > REP_WIDTH'(1)) ? S_REWIND : S_DRAIN;
      end
      S_REWIND: state_nx = S_READ;
      S_DRAIN: begin
        if ((occ == 2'd0) && !inflight) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    occ_nx  = occ + 2'(push) - 2'(pop);
    // done lands in the DRAIN cycle that finds queue and pipe empty
    done_nx = (state_nx == S_DRAIN) && (occ_nx == 2'd0) && !fifo_rd_en;
  end

  // Counters, skid queue and registered outputs
  always_ff @(posedge clk2 or posedge rd_clr) begin
    if (rd_clr) begin
      occ         <= 2'd0;
      inflight    <= 1'b0;
      col         <= '0;
      rep_left    <= '0;
      out_data    <= '0;
      q1_data     <= '0;
      fifo_rd_clr <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef LINE_RD_LAST_EN
      inflight_last <= 1'b0;
      out_last      <= 1'b0;
      q1_last       <= 1'b0;
`endif
    end else begin
      occ         <= occ_nx;
      inflight    <= fifo_rd_en;
      fifo_rd_clr <= (state_nx == S_REWIND);
      busy        <= (state_nx != S_IDLE);
      done        <= done_nx;
`ifdef LINE_RD_LAST_EN
      inflight_last <= fifo_rd_en & col_wrap;
`endif

      if ((state == S_IDLE) && start) begin
        rep_left <= num_rep;
        col      <= '0;
      end else if (fifo_rd_en) begin
        if (col_wrap) begin
          col      <= '0;
          rep_left <= rep_left - REP_WIDTH'(1);
        end else begin
          col <= col + ADD_WIDTH'(1);
        end
      end

      // Head lives in out_data; push and pop in one cycle are both honoured
      case ({push, pop})
        2'b01: begin
          out_data <= q1_data;
`ifdef LINE_RD_LAST_EN
          out_last <= q1_last;
`endif
        end
        2'b10: begin
          if (occ == 2'd0) begin
            out_data <= fifo_data;
`ifdef LINE_RD_LAST_EN
            out_last <= inflight_last;
`endif
          end else begin
            q1_data <= fifo_data;
`ifdef LINE_RD_LAST_EN
            q1_last <= inflight_last;
`endif
          end
        end
        2'b11: begin
          if (occ == 2'd1) begin
            out_data <= fifo_data;
`ifdef LINE_RD_LAST_EN
            out_last <= inflight_last;
`endif
          end else begin
            out_data <= q1_data;
            q1_data  <= fifo_data;
`ifdef LINE_RD_LAST_EN
            out_last <= q1_last;
            q1_last  <= inflight_last;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_rd_sequencer.sv
// Scoreboard bench for line_rd_sequencer with a behavioural line-buffer FIFO (ROW_LEN=4 build).
module tb_line_rd_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned RL = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned RW = 4;

  logic          clk2 = 1'b0;
  logic          rd_clr = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] num_rep = '0;
  logic          fifo_rd_en, fifo_rd_inc, fifo_rd_clr;
  logic [DW-1:0] fifo_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy, done;
`ifdef LINE_RD_LAST_EN
  logic          out_last;
`endif

  line_rd_sequencer #(.DATA_WIDTH(DW), .ROW_LEN(RL), .ADD_WIDTH(AW), .REP_WIDTH(RW)) dut (
    .clk2(clk2), .rd_clr(rd_clr), .start(start), .num_rep(num_rep),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_inc(fifo_rd_inc), .fifo_rd_clr(fifo_rd_clr),
    .fifo_data(fifo_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
`ifdef LINE_RD_LAST_EN
    , .out_last(out_last)
`endif
  );

  always #5 clk2 = ~clk2;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int t0 = 0;

  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  logic [DW-1:0] obs_data[$];
  logic          obs_last[$];
  int            obs_cyc[$];
  int            rd_cyc[$];
  int            clr_cyc[$];
  int            done_cyc[$];
  int            busy_cnt, inc_err, reads, pops, max_out;

  logic [DW-1:0] mem [RL];
  int            ptr;
  logic          en_s = 1'b0;
  logic          clr_s = 1'b0;

  always @(posedge clk2) cyc <= cyc + 1;

  // Behavioural FIFO: registered read data, pointer cleared by fifo_rd_clr
  always @(posedge clk2 or posedge rd_clr) begin
    if (rd_clr) begin
      ptr       <= 0;
      fifo_data <= '0;
    end else if (clr_s) begin
      ptr <= 0;
    end else if (en_s) begin
      fifo_data <= mem[ptr];
      ptr       <= (ptr + 1) % RL;
    end
  end

  // Observation log, sampled mid-cycle
  always @(negedge clk2) begin
    en_s  <= fifo_rd_en & ~rd_clr;
    clr_s <= fifo_rd_clr & ~rd_clr;
    if (!rd_clr) begin
      if (fifo_rd_inc !== fifo_rd_en) inc_err++;
      if (fifo_rd_en) begin rd_cyc.push_back(cyc - t0); reads++; end
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
`ifdef LINE_RD_LAST_EN
        obs_last.push_back(out_last);
`else
        obs_last.push_back(1'b0);
`endif
        obs_cyc.push_back(cyc - t0);
        pops++;
      end
      if (fifo_rd_clr) clr_cyc.push_back(cyc - t0);
      if (done) done_cyc.push_back(cyc - t0);
      if (busy) busy_cnt++;
      if (reads - pops > max_out) max_out = reads - pops;
    end
  end

  task automatic clear_logs();
    exp_data.delete(); exp_last.delete();
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    rd_cyc.delete(); clr_cyc.delete(); done_cyc.delete();
    busy_cnt = 0; inc_err = 0; reads = 0; pops = 0; max_out = 0;
  endtask

  // Start pulse in cycle 0; expected stream goes to the scoreboard; returns in cycle 1
  task automatic do_start(input int rep);
    @(posedge clk2); #1;
    clear_logs();
    t0 = cyc;
    start = 1'b1;
    num_rep = RW'(rep);
    for (int r = 0; r < rep; r++)
      for (int c = 0; c < int'(RL); c++) begin
        exp_data.push_back(DW'(c + 1));
`ifdef LINE_RD_LAST_EN
        exp_last.push_back(c == int'(RL) - 1);
`else
        exp_last.push_back(1'b0);
`endif
      end
    @(posedge clk2); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) @(posedge clk2);
    repeat (3) @(posedge clk2);
    #1;
  endtask

  task automatic test_reset();
    #1 rd_clr = 1'b1;
    #2;
    total_cnt++;
    if ({fifo_rd_en, fifo_rd_inc, fifo_rd_clr, out_valid, busy, done} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000",
               {fifo_rd_en, fifo_rd_inc, fifo_rd_clr, out_valid, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (out_data !== '0) $display("FAIL reset_data: got %0h required 0", out_data);
    else pass_cnt++;
    @(posedge clk2); #1 rd_clr = 1'b0;
  endtask

  task automatic test_basic();
    int exp_oc[8] = '{3, 4, 5, 6, 8, 9, 10, 11};
    int exp_rd[8] = '{1, 2, 3, 4, 6, 7, 8, 9};
    logic [DW-1:0] ed, od;
    logic el, ol;
    int oc, i;
    out_ready = 1'b1;
    do_start(2);
    wait_done(40);
    i = 0;
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      total_cnt++;
      if (obs_data.size() == 0) $display("FAIL basic_item: output %0d missing, required %0d", i, ed);
      else begin
        od = obs_data.pop_front(); ol = obs_last.pop_front(); oc = obs_cyc.pop_front();
        if ({ol, od} !== {el, ed} || oc != exp_oc[i])
          $display("FAIL basic_item: got %0d/last %0b at cycle %0d, required %0d/last %0b at cycle %0d",
                   od, ol, oc, ed, el, exp_oc[i]);
        else pass_cnt++;
      end
      i++;
    end
    total_cnt++;
    if (rd_cyc.size() != 8) $display("FAIL basic_reads: got %0d reads required 8", rd_cyc.size());
    else pass_cnt++;
    for (int k = 0; k < 8 && k < rd_cyc.size(); k++) begin
      total_cnt++;
      if (rd_cyc[k] != exp_rd[k]) $display("FAIL basic_rd_cycle: got %0d required %0d", rd_cyc[k], exp_rd[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (clr_cyc.size() != 1 || clr_cyc[0] != 5)
      $display("FAIL basic_clr: got %0d pulses first at %0d, required 1 at 5",
               clr_cyc.size(), (clr_cyc.size() > 0) ? clr_cyc[0] : -1);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != 12)
      $display("FAIL basic_done: got %0d pulses first at %0d, required 1 at 12",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    else pass_cnt++;
    total_cnt++;
    if (busy_cnt != 12 || inc_err != 0)
      $display("FAIL basic_busy_inc: got busy %0d inc_err %0d, required 12 and 0", busy_cnt, inc_err);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ed, od;
    logic el, ol;
    int stalled;
    do_start(2);
    for (int k = 1; k < 60 && done_cyc.size() == 0; k++) begin
      out_ready = (k < 4 || k > 6);
      @(posedge clk2); #1;
    end
    out_ready = 1'b1;
    wait_done(10);
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      total_cnt++;
      if (obs_data.size() == 0) $display("FAIL bp_item: missing output, required %0d", ed);
      else begin
        od = obs_data.pop_front(); ol = obs_last.pop_front();
        if ({ol, od} !== {el, ed}) $display("FAIL bp_item: got %0d/%0b required %0d/%0b", od, ol, ed, el);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (obs_data.size() != 0) $display("FAIL bp_extra: got %0d extra outputs required 0", obs_data.size());
    else pass_cnt++;
    stalled = 0;
    foreach (rd_cyc[k]) if (rd_cyc[k] >= 4 && rd_cyc[k] <= 6) stalled++;
    total_cnt++;
    if (stalled != 0 || max_out > 2)
      $display("FAIL bp_credit: got %0d reads in stall, max held %0d, required 0 and <=2", stalled, max_out);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != 15 || clr_cyc.size() != 1 || clr_cyc[0] != 8)
      $display("FAIL bp_timing: got done x%0d clr x%0d, required done at 15 and clr at 8",
               done_cyc.size(), clr_cyc.size());
    else pass_cnt++;
  endtask

  task automatic test_zero_rep();
    do_start(0);
    wait_done(10);
    total_cnt++;
    if (rd_cyc.size() != 0 || obs_data.size() != 0)
      $display("FAIL zero_reads: got %0d reads %0d outputs required 0", rd_cyc.size(), obs_data.size());
    else pass_cnt++;
    total_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != 1 || busy_cnt != 1)
      $display("FAIL zero_done: got done x%0d busy cycles %0d, required done at 1 and busy 1",
               done_cyc.size(), busy_cnt);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    logic [DW-1:0] ed, od;
    logic el, ol;
    out_ready = 1'b1;
    do_start(1);
    start = 1'b1; num_rep = RW'(3);
    @(posedge clk2); #1;
    start = 1'b0;
    wait_done(30);
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      total_cnt++;
      if (obs_data.size() == 0) $display("FAIL ign_item: missing output, required %0d", ed);
      else begin
        od = obs_data.pop_front(); ol = obs_last.pop_front();
        if ({ol, od} !== {el, ed}) $display("FAIL ign_item: got %0d/%0b required %0d/%0b", od, ol, ed, el);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (obs_data.size() != 0 || done_cyc.size() != 1 || clr_cyc.size() != 0)
      $display("FAIL ign_count: got %0d extra outputs, done x%0d, clr x%0d, required 0, 1, 0",
               obs_data.size(), done_cyc.size(), clr_cyc.size());
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [DW-1:0] ed, od;
    logic el, ol;
    out_ready = 1'b1;
    do_start(2);
    repeat (6) @(posedge clk2);
    #1 rd_clr = 1'b1;
    #1;
    total_cnt++;
    if ({fifo_rd_en, fifo_rd_inc, fifo_rd_clr, out_valid, busy, done} !== 6'b0 || out_data !== '0)
      $display("FAIL abort_outputs: got ctrl %b data %0h, required all 0",
               {fifo_rd_en, fifo_rd_inc, fifo_rd_clr, out_valid, busy, done}, out_data);
    else pass_cnt++;
    repeat (3) @(posedge clk2);
    #1 rd_clr = 1'b0;
    repeat (5) @(posedge clk2);
    #1;
    total_cnt++;
    if (done_cyc.size() != 0 || busy_cnt != 6)
      $display("FAIL abort_no_done: got done x%0d busy cycles %0d, required 0 and 6", done_cyc.size(), busy_cnt);
    else pass_cnt++;
    do_start(1);
    wait_done(30);
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      total_cnt++;
      if (obs_data.size() == 0) $display("FAIL abort_replay: missing output, required %0d", ed);
      else begin
        od = obs_data.pop_front(); ol = obs_last.pop_front();
        if ({ol, od} !== {el, ed}) $display("FAIL abort_replay: got %0d/%0b required %0d/%0b", od, ol, ed, el);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (done_cyc.size() != 1) $display("FAIL abort_replay_done: got %0d required 1", done_cyc.size());
    else pass_cnt++;
  endtask

  task automatic test_toggle();
    logic [DW-1:0] ed, od;
    logic el, ol;
    do_start(3);
    for (int k = 1; k < 200 && done_cyc.size() == 0; k++) begin
      out_ready = (k % 2 == 0);
      @(posedge clk2); #1;
    end
    out_ready = 1'b1;
    wait_done(10);
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      total_cnt++;
      if (obs_data.size() == 0) $display("FAIL tog_item: missing output, required %0d", ed);
      else begin
        od = obs_data.pop_front(); ol = obs_last.pop_front();
        if ({ol, od} !== {el, ed}) $display("FAIL tog_item: got %0d/%0b required %0d/%0b", od, ol, ed, el);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (obs_data.size() != 0 || clr_cyc.size() != 2 || done_cyc.size() != 1 || max_out > 2)
      $display("FAIL tog_summary: got extra %0d clr x%0d done x%0d max held %0d, required 0, 2, 1, <=2",
               obs_data.size(), clr_cyc.size(), done_cyc.size(), max_out);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < int'(RL); i++) mem[i] = DW'(i + 1);
    clear_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_rep();
    test_start_ignored();
    test_abort();
    test_toggle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
